// File: rtl/control_sequencer.sv
// Microcoded control sequencer: fetch/decode/operand/writeback FSM driving the datapath control word.
// Optional conditional jumps (JZ/JC on opcode 110xxxxx) are enabled by defining SEQ_COND_JUMP_EN.
module control_sequencer #(
   parameter int SZ = 28
) (
   input  logic          CLK,
   input  logic          RST,
   input  logic [7:0]    ibus,
   input  logic          mem_ready,
   input  logic [7:0]    flags,
   output logic [SZ-1:0] CS_bus,
   output logic          halted
);

   localparam int B_ADD      = 0;
   localparam int B_COMP     = 1;
   localparam int B_SUB      = 2;
   localparam int B_XORR     = 3;
   localparam int B_ANDD     = 4;
   localparam int B_ORR      = 5;
   localparam int B_ACC_IN   = 6;
   localparam int B_PC_OUT   = 8;
   localparam int B_PC_INC   = 9;
   localparam int B_PC_IN    = 10;
   localparam int B_MAR_IN   = 11;
   localparam int B_MEM_RD   = 12;
   localparam int B_IR_IN    = 13;
   localparam int B_Z_OUT    = 25;

   typedef enum logic [2:0] {F1, F2, DEC, O1, O2, WB, HALT} state_t;

   state_t        state_q;
   logic [7:0]    opcode_q;
   logic          cond_q;
   logic [2:0]    op_cls_s;
   logic          is_jump_s;
   logic [SZ-1:0] cs_s;
   logic          unused_s;

   assign op_cls_s = opcode_q[7:5];
   assign unused_s = ^{flags[7], flags[5:1], opcode_q[4:1]};

`ifdef SEQ_COND_JUMP_EN
   assign is_jump_s = (op_cls_s == 3'b110);
`else
   assign is_jump_s = 1'b0;
`endif

   // State, opcode latch and jump-condition sample
   always_ff @(posedge CLK) begin
      if (RST) begin
         state_q  <= F1;
         opcode_q <= 8'h00;
         cond_q   <= 1'b0;
      end else begin
         case (state_q)
            F1: state_q <= F2;
            F2: begin
               if (mem_ready) begin
                  opcode_q <= ibus;
                  state_q  <= DEC;
               end
            end
            DEC: begin
               // bit 0 selects JC (carry) over JZ (zero)
               cond_q <= opcode_q[0] ? flags[0] : flags[6];
               if (op_cls_s == 3'b111) begin
                  state_q <= opcode_q[0] ? HALT : F1;
               end else if (op_cls_s == 3'b110) begin
                  state_q <= is_jump_s ? O1 : F1;
               end else begin
                  state_q <= O1;
               end
            end
            O1: state_q <= O2;
            O2: begin
               if (mem_ready) begin
                  state_q <= is_jump_s ? F1 : WB;
               end
            end
            WB:      state_q <= F1;
            HALT:    state_q <= HALT;
            default: state_q <= F1;
         endcase
      end
   end

   // Control word decode; mem_ready gates the single-cycle latch strobes
   always_comb begin
      cs_s = '0;
      if (RST) begin
         cs_s = '0;
      end else begin
         case (state_q)
            F1, O1: begin
               cs_s[B_PC_OUT] = 1'b1;
               cs_s[B_MAR_IN] = 1'b1;
            end
            F2: begin
               cs_s[B_MEM_RD] = 1'b1;
               if (mem_ready) begin
                  cs_s[B_IR_IN]  = 1'b1;
                  cs_s[B_PC_INC] = 1'b1;
               end else begin
                  cs_s[B_IR_IN]  = 1'b0;
               end
            end
            O2: begin
               cs_s[B_MEM_RD] = 1'b1;
               if (mem_ready) begin
                  if (is_jump_s) begin
                     if (cond_q) begin
                        cs_s[B_PC_IN]  = 1'b1;
                     end else begin
                        cs_s[B_PC_INC] = 1'b1;
                     end
                  end else begin
                     cs_s[B_PC_INC] = 1'b1;
                     case (op_cls_s)
                        3'b000: cs_s[B_ADD]  = 1'b1;
                        3'b001: cs_s[B_SUB]  = 1'b1;
                        3'b010: cs_s[B_XORR] = 1'b1;
                        3'b011: cs_s[B_ANDD] = 1'b1;
                        3'b100: cs_s[B_ORR]  = 1'b1;
                        3'b101: begin
                           cs_s[B_SUB]  = 1'b1;
                           cs_s[B_COMP] = 1'b1;
                        end
                        default: cs_s[B_ADD] = 1'b0;
                     endcase
                  end
               end else begin
                  cs_s[B_PC_INC] = 1'b0;
               end
            end
            WB: begin
               if (op_cls_s != 3'b101) begin
                  cs_s[B_Z_OUT]  = 1'b1;
                  cs_s[B_ACC_IN] = 1'b1;
               end else begin
                  cs_s[B_Z_OUT]  = 1'b0;
               end
            end
            default: cs_s = '0;
         endcase
      end
   end

   assign CS_bus = cs_s;
   assign halted = (state_q == HALT) && !RST;

endmodule

// File: tb/tb_control_sequencer.sv
// Randomized bench for control_sequencer: expands each instruction into its expected per-cycle control trace.
// Honors SEQ_COND_JUMP_EN in the reference expansion.
module tb_control_sequencer;

   localparam int SZ = 28;

   localparam logic [SZ-1:0] ADD    = SZ'(1) << 0;
   localparam logic [SZ-1:0] COMP   = SZ'(1) << 1;
   localparam logic [SZ-1:0] SUB    = SZ'(1) << 2;
   localparam logic [SZ-1:0] XORR   = SZ'(1) << 3;
   localparam logic [SZ-1:0] ANDD   = SZ'(1) << 4;
   localparam logic [SZ-1:0] ORR    = SZ'(1) << 5;
   localparam logic [SZ-1:0] ACC_IN = SZ'(1) << 6;
   localparam logic [SZ-1:0] PC_OUT = SZ'(1) << 8;
   localparam logic [SZ-1:0] PC_INC = SZ'(1) << 9;
   localparam logic [SZ-1:0] PC_IN  = SZ'(1) << 10;
   localparam logic [SZ-1:0] MAR_IN = SZ'(1) << 11;
   localparam logic [SZ-1:0] MEM_RD = SZ'(1) << 12;
   localparam logic [SZ-1:0] IR_IN  = SZ'(1) << 13;
   localparam logic [SZ-1:0] Z_OUT  = SZ'(1) << 25;

`ifdef SEQ_COND_JUMP_EN
   localparam bit JUMP_EN = 1'b1;
`else
   localparam bit JUMP_EN = 1'b0;
`endif

   logic          CLK;
   logic          RST;
   logic [7:0]    ibus;
   logic          mem_ready;
   logic [7:0]    flags;
   logic [SZ-1:0] CS_bus;
   logic          halted;

   int n_checks = 0;
   int n_err    = 0;

   control_sequencer #(.SZ(SZ)) dut (
      .CLK       (CLK),
      .RST       (RST),
      .ibus      (ibus),
      .mem_ready (mem_ready),
      .flags     (flags),
      .CS_bus    (CS_bus),
      .halted    (halted)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   // One clock: drive inputs, check the settled control word, advance past the edge.
   task automatic step(input logic rst, input logic rdy, input logic [7:0] bus, input logic [7:0] fl,
                       input logic [SZ-1:0] exp_cs, input logic exp_h, input string tag);
      RST = rst; mem_ready = rdy; ibus = bus; flags = fl;
      #1;
      chk({tag, "/cs"}, 32'(CS_bus), 32'(exp_cs));
      chk({tag, "/halt"}, 32'(halted), 32'(exp_h));
      @(posedge CLK);
      #1;
   endtask

   function automatic logic [7:0] rnd8();
      return 8'($urandom_range(0, 255));
   endfunction

   function automatic logic rnd1();
      return 1'($urandom_range(0, 1));
   endfunction

   task automatic do_reset(input int n);
      for (int i = 0; i < n; i++) step(1'b1, rnd1(), rnd8(), rnd8(), '0, 1'b0, "reset");
   endtask

   // Expected trace of one instruction from the instruction-set rules; HLT is followed by a reset pulse.
   task automatic play(input logic [7:0] op, input int wf, input int wo, input logic [7:0] fl);
      logic [2:0] cls;
      logic       jump, taken;
      logic [SZ-1:0] alu;
      cls   = op[7:5];
      jump  = JUMP_EN && (cls == 3'b110);
      taken = op[0] ? fl[0] : fl[6];
      case (cls)
         3'd0: alu = ADD;
         3'd1: alu = SUB;
         3'd2: alu = XORR;
         3'd3: alu = ANDD;
         3'd4: alu = ORR;
         3'd5: alu = SUB | COMP;
         default: alu = '0;
      endcase
      step(1'b0, rnd1(), rnd8(), rnd8(), PC_OUT | MAR_IN, 1'b0, "F1");
      for (int i = 0; i < wf; i++) step(1'b0, 1'b0, rnd8(), rnd8(), MEM_RD, 1'b0, "F2wait");
      step(1'b0, 1'b1, op, rnd8(), MEM_RD | IR_IN | PC_INC, 1'b0, "F2");
      step(1'b0, rnd1(), rnd8(), fl, '0, 1'b0, "DEC");
      if (cls == 3'b111 && op[0]) begin
         for (int i = 0; i < 20; i++) step(1'b0, rnd1(), rnd8(), rnd8(), '0, 1'b1, "HALT");
         do_reset(1);
      end else if (cls == 3'b111 || (cls == 3'b110 && !jump)) begin
         // NOP: next instruction starts straight away
      end else begin
         step(1'b0, rnd1(), rnd8(), rnd8(), PC_OUT | MAR_IN, 1'b0, "O1");
         for (int i = 0; i < wo; i++) step(1'b0, 1'b0, rnd8(), rnd8(), MEM_RD, 1'b0, "O2wait");
         if (jump)
            step(1'b0, 1'b1, rnd8(), rnd8(), MEM_RD | (taken ? PC_IN : PC_INC), 1'b0, "O2jmp");
         else begin
            step(1'b0, 1'b1, rnd8(), rnd8(), MEM_RD | PC_INC | alu, 1'b0, "O2");
            step(1'b0, rnd1(), rnd8(), rnd8(), (cls == 3'b101) ? '0 : (Z_OUT | ACC_IN), 1'b0, "WB");
         end
      end
   endtask

   // Reset lands while the fetch is stalled; the opcode must never be taken.
   task automatic reset_in_fetch(input int w);
      step(1'b0, rnd1(), rnd8(), rnd8(), PC_OUT | MAR_IN, 1'b0, "F1");
      for (int i = 0; i < w; i++) step(1'b0, 1'b0, rnd8(), rnd8(), MEM_RD, 1'b0, "F2wait");
      step(1'b1, 1'b1, 8'hE1, rnd8(), '0, 1'b0, "F2rst");
   endtask

   initial begin
      RST = 1'b1; mem_ready = 1'b0; ibus = 8'h00; flags = 8'h00;
      @(posedge CLK);
      #1;
      do_reset(2);

      play(8'h00, 0, 0, 8'h00);
      play(8'hA0, 0, 3, 8'h00);
      play(8'hE0, 1, 0, 8'h00);
      play(8'hC0, 0, 0, 8'h40);
      play(8'hC0, 0, 0, 8'h00);
      play(8'hC1, 2, 1, 8'h01);
      play(8'hE1, 0, 0, 8'h00);
      reset_in_fetch(2);
      play(8'h20, 0, 0, 8'h00);

      for (int n = 0; n < 250; n++) begin
         if ($urandom_range(0, 19) == 0)
            reset_in_fetch($urandom_range(0, 3));
         else
            play(rnd8(), $urandom_range(0, 3), $urandom_range(0, 3), rnd8());
      end

      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end

endmodule
